// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types: divider FSM state encoding and default operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/div_addsub_unit.sv
// Combinational (WIDTH+1)-bit adder/subtractor shared by the divider iteration and fix-up steps.
module div_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    input  logic           i_sub,
    output logic [WIDTH:0] o_y
);

    assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring divider with start/ready/done handshake; WIDTH+2 cycles per divide.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_neg_n;
    logic             w_neg_d;
    logic [WIDTH-1:0] w_abs_n;
    logic [WIDTH-1:0] w_abs_d;
    logic [WIDTH:0]   w_as_a;
    logic [WIDTH:0]   w_as_b;
    logic [WIDTH:0]   w_as_y;
    logic             w_as_sub;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;

`ifdef DIVIDER_SIGNED_EN
    assign w_neg_n = dividend[WIDTH-1];
    assign w_neg_d = divisor[WIDTH-1];
`else
    assign w_neg_n = 1'b0;
    assign w_neg_d = 1'b0;
`endif

    // Magnitudes fit in WIDTH unsigned bits even for the most negative operand.
    assign w_abs_n = w_neg_n ? -dividend : dividend;
    assign w_abs_d = w_neg_d ? -divisor  : divisor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= DIV_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = DIV_RUN;
            end
            DIV_RUN:  if (r_count == '0) w_state_next = DIV_FIX;
            DIV_FIX:  if (r_count == '0) w_state_next = DIV_DONE;
            DIV_DONE: begin
                done         = 1'b1;
                w_state_next = DIV_IDLE;
            end
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    // RUN: shift {prem, quo} left and add/subtract |divisor| by the old remainder sign.
    // FIX: add |divisor| back onto a negative remainder.
    always_comb begin
        w_as_a   = {r_prem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_as_b   = {1'b0, r_dvs};
        w_as_sub = ~r_prem[WIDTH];
        if (r_state == DIV_FIX) begin
            w_as_a   = r_prem;
            w_as_sub = 1'b0;
        end
    end

    div_addsub_unit #(.WIDTH(WIDTH)) u_addsub (
        .i_a   (w_as_a),
        .i_b   (w_as_b),
        .i_sub (w_as_sub),
        .o_y   (w_as_y)
    );

    assign w_q_final = r_dbz ? '1 : (r_neg_q ? -r_quo : r_quo);
    assign w_r_final = r_neg_r ? -r_prem[WIDTH-1:0] : r_prem[WIDTH-1:0];

    // FIX spans two cycles: count 1 restores the remainder, count 0 applies signs and publishes.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_prem        <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dbz         <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: if (start) begin
                    r_count       <= CNT_LAST;
                    r_prem        <= '0;
                    r_quo         <= w_abs_n;
                    r_dvs         <= w_abs_d;
                    r_neg_q       <= w_neg_n ^ w_neg_d;
                    r_neg_r       <= w_neg_n;
                    r_dbz         <= (divisor == '0);
                    r_quotient    <= '0;
                    r_remainder   <= '0;
                    r_div_by_zero <= 1'b0;
                end
                DIV_RUN: begin
                    r_prem  <= w_as_y;
                    r_quo   <= {r_quo[WIDTH-2:0], ~w_as_y[WIDTH]};
                    r_count <= (r_count == '0) ? CNT_ONE : r_count - CNT_ONE;
                end
                DIV_FIX: begin
                    if (r_count != '0) begin
                        if (r_prem[WIDTH]) r_prem <= w_as_y;
                        r_count <= r_count - CNT_ONE;
                    end else begin
                        r_quotient    <= w_q_final;
                        r_remainder   <= w_r_final;
                        r_div_by_zero <= r_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider; expectations come from SV / and % (signed when DIVIDER_SIGNED_EN).
module tb_seq_divider;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t sb_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t e;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end
`ifdef DIVIDER_SIGNED_EN
        else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            e.q = a;
            e.r = '0;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
`else
        else begin
            e.q = a / b;
            e.r = a % b;
        end
`endif
        return e;
    endfunction

    // Drives one request (holding start until ready), pushes the expectation, waits for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit now,
                          output res_t first, output res_t last, output int lat,
                          output int waited, output logic rdy_run);
        if (!now) @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb_q.push_back(model(a, b));
        waited = 0;
        while (ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        first    = {quotient, remainder, div_by_zero};
        rdy_run  = ready;
        lat      = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        last = {quotient, remainder, div_by_zero};
    endtask

    task automatic test_reset();
        logic [2*W+2:0] want;
        want     = {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0};
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ready, done, quotient, remainder, div_by_zero} !== want)
            $display("FAIL reset_state: got %h want %h", {ready, done, quotient, remainder, div_by_zero}, want);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        res_t first, last, exp;
        int   lat, waited;
        logic rdy_run;
        run_op(8'd100, 8'd7, 1'b0, first, last, lat, waited, rdy_run);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (rdy_run !== 1'b0) $display("FAIL basic_ready_drop: got %b want 0", rdy_run);
        else n_pass++;
        n_checks++;
        if (last !== exp) $display("FAIL basic_result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                                   last.q, last.r, last.dbz, exp.q, exp.r, exp.dbz);
        else n_pass++;
        n_checks++;
        if (last !== {8'd14, 8'd2, 1'b0}) $display("FAIL basic_100_7: got q=%0d r=%0d z=%b want q=14 r=2 z=0",
                                                   last.q, last.r, last.dbz);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, ready} !== 2'b01) $display("FAIL basic_done_pulse: got done=%b ready=%b want done=0 ready=1", done, ready);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== exp)
            $display("FAIL basic_hold: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     quotient, remainder, div_by_zero, exp.q, exp.r, exp.dbz);
        else n_pass++;
    endtask

    task automatic test_sign_overflow();
        logic [W-1:0] ta[3] = '{8'h9C, 8'd100, 8'h80};
        logic [W-1:0] tb[3] = '{8'd7,  8'hF9,  8'hFF};
`ifdef DIVIDER_SIGNED_EN
        logic [W-1:0] kq[3] = '{8'hF2, 8'hF2, 8'h80};
        logic [W-1:0] kr[3] = '{8'hFE, 8'h02, 8'h00};
`else
        logic [W-1:0] kq[3] = '{8'd22, 8'd0,   8'd0};
        logic [W-1:0] kr[3] = '{8'd2,  8'd100, 8'd128};
`endif
        res_t first, last, exp;
        int   lat, waited;
        logic rdy_run;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b0, first, last, lat, waited, rdy_run);
            exp = sb_q.pop_front();
            n_checks++;
            if (last !== exp || last !== {kq[i], kr[i], 1'b0} || lat !== LAT)
                $display("FAIL sign_case_%0d: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=0 lat=%0d",
                         i, last.q, last.r, last.dbz, lat, kq[i], kr[i], LAT);
            else n_pass++;
        end
    endtask

    task automatic test_div_by_zero();
        res_t first, last, exp;
        int   lat, waited;
        logic rdy_run;
        run_op(8'd7, 8'd0, 1'b0, first, last, lat, waited, rdy_run);
        exp = sb_q.pop_front();
        n_checks++;
        if (last !== exp || last !== {8'hFF, 8'd7, 1'b1})
            $display("FAIL dbz_result: got q=%h r=%h z=%b want q=ff r=07 z=1", last.q, last.r, last.dbz);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL dbz_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (div_by_zero !== 1'b1) $display("FAIL dbz_hold: got %b want 1", div_by_zero);
        else n_pass++;
        run_op(8'd9, 8'd3, 1'b0, first, last, lat, waited, rdy_run);
        exp = sb_q.pop_front();
        n_checks++;
        if (first !== '0) $display("FAIL dbz_clear_on_accept: got q=%h r=%h z=%b want all 0", first.q, first.r, first.dbz);
        else n_pass++;
        n_checks++;
        if (last !== exp || last !== {8'd3, 8'd0, 1'b0})
            $display("FAIL dbz_next_op: got q=%h r=%h z=%b want q=03 r=00 z=0", last.q, last.r, last.dbz);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        res_t exp, got;
        int   n_done, lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        sb_q.push_back(model(8'd100, 8'd7));
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        lat    = 0;
        got    = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (i == 4) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    lat = i;
                    got = {quotient, remainder, div_by_zero};
                end
            end
        end
        exp = sb_q.pop_front();
        n_checks++;
        if (n_done !== 1) $display("FAIL ignore_done_count: got %0d want 1", n_done);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL ignore_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (got !== exp) $display("FAIL ignore_result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                                  got.q, got.r, got.dbz, exp.q, exp.r, exp.dbz);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t first, last, exp;
        int   lat, waited, n_done;
        logic rdy_run;
        logic [2*W+2:0] want;
        want = {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0};
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready, done, quotient, remainder, div_by_zero} !== want)
            $display("FAIL reset_mid_state: got %h want %h", {ready, done, quotient, remainder, div_by_zero}, want);
        else n_pass++;
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) $display("FAIL reset_mid_no_done: got %0d pulses want 0", n_done);
        else n_pass++;
        run_op(8'd200, 8'd3, 1'b0, first, last, lat, waited, rdy_run);
        exp = sb_q.pop_front();
`ifdef DIVIDER_SIGNED_EN
        n_checks++;
        if (last !== exp || last !== {8'hEE, 8'hFE, 1'b0})
            $display("FAIL reset_mid_200_3: got q=%h r=%h z=%b want q=ee r=fe z=0", last.q, last.r, last.dbz);
        else n_pass++;
`else
        n_checks++;
        if (last !== exp || last !== {8'd66, 8'd2, 1'b0})
            $display("FAIL reset_mid_200_3: got q=%0d r=%0d z=%b want q=66 r=2 z=0", last.q, last.r, last.dbz);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        res_t first, last, exp;
        int   lat, waited;
        logic rdy_run;
        run_op(8'd50, 8'd6, 1'b0, first, last, lat, waited, rdy_run);
        exp = sb_q.pop_front();
        n_checks++;
        if (last !== exp) $display("FAIL b2b_first: got q=%h r=%h want q=%h r=%h", last.q, last.r, exp.q, exp.r);
        else n_pass++;
        run_op(8'd27, 8'd4, 1'b1, first, last, lat, waited, rdy_run);
        exp = sb_q.pop_front();
        n_checks++;
        if (waited !== 1) $display("FAIL b2b_accept_delay: got %0d cycles want 1", waited);
        else n_pass++;
        n_checks++;
        if (last !== exp || lat !== LAT)
            $display("FAIL b2b_second: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                     last.q, last.r, last.dbz, lat, exp.q, exp.r, exp.dbz, LAT);
        else n_pass++;
    endtask

    task automatic test_random();
        res_t         first, last, exp;
        int           lat, waited;
        logic         rdy_run;
        logic [W-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(a, b, 1'b0, first, last, lat, waited, rdy_run);
            exp = sb_q.pop_front();
            n_checks++;
            if (last !== exp || lat !== LAT)
                $display("FAIL random_%0d (%h/%h): got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                         i, a, b, last.q, last.r, last.dbz, lat, exp.q, exp.r, exp.dbz, LAT);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_overflow();
        test_div_by_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
